// File: rtl/iic_slave_regif.sv
// I2C target at a fixed device address: decodes byte writes and random or
// sequential reads and turns them into single-cycle register-bus accesses.
module iic_slave_regif #(
    parameter logic [6:0] DEVICE_ADDR = 7'b1010_011,
    parameter bit         ADDR_16BIT  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        xfer_done
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_P
    } state_t;

    state_t      state, state_n;
    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        rx_state, byte_end;
    logic [2:0]  cnt, cnt_n;
    logic        full, full_n;
    logic [7:0]  shreg, shreg_n;
    logic        rw, rw_n;
    logic        sda_oe, sda_oe_n;
    logic [15:0] addr_n;
    logic [7:0]  wdata_n;
    logic        we_n, re_n, busy_n, done_n;

    // Register pointer advance; 8-bit mode keeps the upper byte at zero.
    function automatic logic [15:0] next_ptr(input logic [15:0] a);
        if (ADDR_16BIT)
            return a + 16'd1;
        return {8'h00, a[7:0] + 8'd1};
    endfunction

    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Stage p0..p2: synchroniser, edges taken between p1 and p2
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= i2c_scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= i2c_sda;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
    assign stop_det  = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
    assign rx_state  = (state == DEV_ADDR) || (state == ADDR_H) ||
                       (state == ADDR_L) || (state == WR_DATA) || (state == RD_DATA);
    assign byte_end  = scl_fall & full;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        full_n   = full;
        shreg_n  = shreg;
        rw_n     = rw;
        sda_oe_n = sda_oe;
        addr_n   = reg_addr;
        wdata_n  = reg_wdata;
        we_n     = 1'b0;
        re_n     = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;

        if (reg_we || reg_re)
            addr_n = next_ptr(reg_addr);
        if (reg_re)
            shreg_n = reg_rdata;

        if (start_det) begin
            state_n  = DEV_ADDR;
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            sda_oe_n = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            cnt_n    = 3'd0;
            full_n   = 1'b0;
            sda_oe_n = 1'b0;
            done_n   = busy;
            busy_n   = 1'b0;
        end else begin
            // Bit count runs on every SCL rise of a data byte; full marks bit 8 seen.
            if (scl_rise && rx_state) begin
                if (state != RD_DATA)
                    shreg_n = {shreg[6:0], sda_p1};
                if (cnt == 3'd7)
                    full_n = 1'b1;
                else
                    cnt_n = cnt + 3'd1;
            end
            if (byte_end) begin
                full_n = 1'b0;
                cnt_n  = 3'd0;
            end

            case (state)
                DEV_ADDR: if (byte_end) begin
                    if (shreg[7:1] == DEVICE_ADDR) begin
                        state_n  = ACK_DEV;
                        sda_oe_n = 1'b1;
                        rw_n     = shreg[0];
                        busy_n   = 1'b1;
                    end else begin
                        state_n = WAIT_P;
                        busy_n  = 1'b0;
                    end
                end
                ACK_DEV: begin
                    if (scl_rise && rw)
                        re_n = 1'b1;
                    if (scl_fall) begin
                        if (rw) begin
                            state_n  = RD_DATA;
                            sda_oe_n = ~shreg[7];
                        end else begin
                            state_n  = ADDR_16BIT ? ADDR_H : ADDR_L;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                ADDR_H: if (byte_end) begin
                    addr_n   = {shreg, reg_addr[7:0]};
                    state_n  = ACK_AH;
                    sda_oe_n = 1'b1;
                end
                ACK_AH: if (scl_fall) begin
                    state_n  = ADDR_L;
                    sda_oe_n = 1'b0;
                end
                ADDR_L: if (byte_end) begin
                    addr_n   = ADDR_16BIT ? {reg_addr[15:8], shreg} : {8'h00, shreg};
                    state_n  = ACK_AL;
                    sda_oe_n = 1'b1;
                end
                ACK_AL: if (scl_fall) begin
                    state_n  = WR_DATA;
                    sda_oe_n = 1'b0;
                end
                WR_DATA: if (byte_end) begin
                    we_n     = 1'b1;
                    wdata_n  = shreg;
                    state_n  = ACK_WR;
                    sda_oe_n = 1'b1;
                end
                ACK_WR: if (scl_fall) begin
                    state_n  = WR_DATA;
                    sda_oe_n = 1'b0;
                end
                RD_DATA: if (scl_fall) begin
                    if (full) begin
                        state_n  = RD_ACK;
                        sda_oe_n = 1'b0;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        sda_oe_n = ~shreg[6];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_p1)
                            re_n = 1'b1;
                        else
                            state_n = WAIT_P;
                    end else if (scl_fall) begin
                        state_n  = RD_DATA;
                        sda_oe_n = ~shreg[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            full      <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 16'h0000;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            full      <= full_n;
            sda_oe    <= sda_oe_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            busy      <= busy_n;
            xfer_done <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        rw    <= rw_n;
    end

endmodule

// File: tb/tb_iic_slave_regif.sv
// Bench for iic_slave_regif: bit-banged I2C master, register-bus scoreboard,
// one instance in 16-bit address mode and one in 8-bit mode.
`timescale 1ns/1ps
module tb_iic_slave_regif;

    localparam time Q = 100ns;

    typedef struct packed {
        logic        is_re;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        scl0, scl1;
    wire         sda0, sda1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1, rdata0, rdata1;
    logic        we0, we1, re0, re1, busy0, busy1, done0, done1;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          drv_cnt = 0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    assign scl0 = sel ? 1'b1 : m_scl;
    assign scl1 = sel ? m_scl : 1'b1;
    assign sda0 = (!sel && !m_sda) ? 1'b0 : 1'bz;
    assign sda1 = (sel && !m_sda) ? 1'b0 : 1'bz;
    pullup (sda0);
    pullup (sda1);

    // Register file model: read data is a fixed function of the address.
    function automatic logic [7:0] rd_model(input logic [15:0] a);
        return a[7:0] ^ 8'h2C;
    endfunction

    always_comb rdata0 = rd_model(addr0);
    always_comb rdata1 = rd_model(addr1);

    iic_slave_regif #(.DEVICE_ADDR(7'b1010_011), .ADDR_16BIT(1'b1)) dut16 (
        .clk(clk), .rst(rst), .i2c_scl(scl0), .i2c_sda(sda0),
        .reg_addr(addr0), .reg_wdata(wdata0), .reg_we(we0), .reg_re(re0),
        .reg_rdata(rdata0), .busy(busy0), .xfer_done(done0)
    );

    iic_slave_regif #(.DEVICE_ADDR(7'b1010_011), .ADDR_16BIT(1'b0)) dut8 (
        .clk(clk), .rst(rst), .i2c_scl(scl1), .i2c_sda(sda1),
        .reg_addr(addr1), .reg_wdata(wdata1), .reg_we(we1), .reg_re(re1),
        .reg_rdata(rdata1), .busy(busy1), .xfer_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input logic is_re, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_extra_strobe", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check("sb_kind", is_re, e.is_re);
            check("sb_addr", a, e.addr);
            if (!is_re)
                check("sb_wdata", d, e.data);
        end
    endtask

    // Monitor samples on the falling clock edge, mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (we0 || re0) sb_pop(re0, addr0, wdata0);
            if (we1 || re1) sb_pop(re1, addr1, wdata1);
            if (we0 && re0) check("we_re_overlap16", 1, 0);
            if (we1 && re1) check("we_re_overlap8", 1, 0);
            done_cnt += int'(done0) + int'(done1);
            busy_cnt += int'(busy0) + int'(busy1);
            if (m_sda && ((!sel && !sda0) || (sel && !sda1)))
                drv_cnt++;
        end
    end

    function automatic logic bus_sda();
        return sel ? sda1 : sda0;
    endfunction

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; #Q;
        m_scl = 1'b1; #Q; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        b = bus_sda(); #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--)
            write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic push(input logic is_re, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        e.is_re = is_re;
        e.addr  = a;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic send(input string tag, input logic [7:0] v, input logic exp_ack);
        logic ack;
        write_byte(v, ack);
        check(tag, ack, exp_ack);
    endtask

    initial begin
        int          done_base, drv_base, busy_base;
        logic [7:0]  rd;
        logic        b;

        repeat (4) @(negedge clk);
        check("rst_sda", sda0, 1'b1);
        check("rst_busy", busy0, 1'b0);
        check("rst_we_re", {we0, re0}, 2'b00);
        check("rst_done", done0, 1'b0);
        check("rst_addr", addr0, 16'h0000);
        check("rst_wdata", wdata0, 8'h00);
        rst = 1'b0;
        #Q;

        // T1: 16-bit write
        done_base = done_cnt;
        push(1'b0, 16'h1234, 8'hA5);
        i2c_start();
        send("t1_ack_dev", 8'hA6, 1'b0);
        send("t1_ack_ah", 8'h12, 1'b0);
        send("t1_ack_al", 8'h34, 1'b0);
        send("t1_ack_wr", 8'hA5, 1'b0);
        i2c_stop();
        #(2*Q);
        check("t1_done", done_cnt - done_base, 1);
        check("t1_sb_empty", sb.size(), 0);

        // T2: random read
        done_base = done_cnt;
        push(1'b1, 16'h0010, 8'h00);
        i2c_start();
        send("t2_ack_dev", 8'hA6, 1'b0);
        send("t2_ack_ah", 8'h00, 1'b0);
        send("t2_ack_al", 8'h10, 1'b0);
        i2c_start();
        send("t2_ack_rd", 8'hA7, 1'b0);
        read_byte(rd, 1'b1);
        check("t2_rdata", rd, 8'h3C);
        i2c_stop();
        #(2*Q);
        check("t2_done", done_cnt - done_base, 1);
        check("t2_sb_empty", sb.size(), 0);

        // T3: foreign address
        done_base = done_cnt;
        drv_base  = drv_cnt;
        busy_base = busy_cnt;
        i2c_start();
        send("t3_nack_dev", 8'hA0, 1'b1);
        send("t3_nack_byte", 8'h12, 1'b1);
        i2c_stop();
        #(2*Q);
        check("t3_sda_driven", drv_cnt - drv_base, 0);
        check("t3_busy", busy_cnt - busy_base, 0);
        check("t3_done", done_cnt - done_base, 0);
        check("t3_sb_empty", sb.size(), 0);

        // T4: burst write across FFFF
        push(1'b0, 16'hFFFF, 8'h11);
        push(1'b0, 16'h0000, 8'h22);
        i2c_start();
        send("t4_ack_dev", 8'hA6, 1'b0);
        send("t4_ack_ah", 8'hFF, 1'b0);
        send("t4_ack_al", 8'hFF, 1'b0);
        send("t4_ack_wr0", 8'h11, 1'b0);
        send("t4_ack_wr1", 8'h22, 1'b0);
        i2c_stop();
        #(2*Q);
        check("t4_sb_empty", sb.size(), 0);

        // T5: 8-bit address mode, sequential read wrapping 00FF -> 0000
        sel = 1'b1;
        #Q;
        done_base = done_cnt;
        push(1'b1, 16'h00FF, 8'h00);
        push(1'b1, 16'h0000, 8'h00);
        push(1'b1, 16'h0001, 8'h00);
        i2c_start();
        send("t5_ack_dev", 8'hA6, 1'b0);
        send("t5_ack_al", 8'hFF, 1'b0);
        i2c_start();
        send("t5_ack_rd", 8'hA7, 1'b0);
        read_byte(rd, 1'b0);
        check("t5_rd0", rd, 8'hD3);
        read_byte(rd, 1'b0);
        check("t5_rd1", rd, 8'h2C);
        read_byte(rd, 1'b1);
        check("t5_rd2", rd, 8'h2D);
        i2c_stop();
        #(2*Q);
        check("t5_done", done_cnt - done_base, 1);
        check("t5_sb_empty", sb.size(), 0);
        sel = 1'b0;
        #Q;

        // T6: reset while the target drives a read bit
        push(1'b1, 16'h0020, 8'h00);
        i2c_start();
        send("t6_ack_dev", 8'hA6, 1'b0);
        send("t6_ack_ah", 8'h00, 1'b0);
        send("t6_ack_al", 8'h20, 1'b0);
        i2c_start();
        send("t6_ack_rd", 8'hA7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            read_bit(b);
            check("t6_bit", b, 1'b0);
        end
        check("t6_pre_rst_sda", sda0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_sda_released", sda0, 1'b1);
        check("t6_busy", busy0, 1'b0);
        check("t6_addr", addr0, 16'h0000);
        i2c_stop();
        #(2*Q);
        done_base = done_cnt;
        push(1'b0, 16'h0005, 8'h77);
        i2c_start();
        send("t6_ack_dev2", 8'hA6, 1'b0);
        send("t6_ack_ah2", 8'h00, 1'b0);
        send("t6_ack_al2", 8'h05, 1'b0);
        send("t6_ack_wr2", 8'h77, 1'b0);
        i2c_stop();
        #(2*Q);
        check("t6_done", done_cnt - done_base, 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
